// File: rtl/dma_burst_streamer.sv
// dma_burst_streamer: splits one (address, byte count) descriptor into AXI burst
// requests with unaligned head/tail beats, 4 KB splitting, abort and done reporting.
module dma_burst_streamer #(
    parameter int STREAM_TYPE = 0,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 512,
    parameter int MAX_BEATS   = 256,
    parameter int BYTES_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   desc_src_addr_i,
    input  logic [ADDR_WIDTH-1:0]   desc_dst_addr_i,
    input  logic [BYTES_WIDTH-1:0]  desc_bytes_i,
    input  logic                    abort_i,
    output logic                    req_valid_o,
    input  logic                    req_ready_i,
    output logic [ADDR_WIDTH-1:0]   req_addr_o,
    output logic [7:0]              req_len_o,
    output logic [2:0]              req_size_o,
    output logic [DATA_WIDTH/8-1:0] req_strb_o,
    output logic                    req_last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    aborted_o
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int LB  = $clog2(BPB);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [BYTES_WIDTH-1:0] r_rem;
    logic                   r_valid;
    logic [ADDR_WIDTH-1:0]  r_req_addr;
    logic [7:0]             r_len;
    logic [2:0]             r_size;
    logic [BPB-1:0]         r_strb;
    logic                   r_last;
    logic                   r_done;
    logic                   r_aborted;

    // head/tail: one narrow beat covering [off .. off+n-1] of the current beat
    logic [LB-1:0]          w_off;
    logic                   w_head;
    logic [LB:0]            w_room;
    logic [LB:0]            w_n;
    logic [LB:0]            w_end;
    logic [BPB-1:0]         w_strb;
    // body: full beats limited by burst depth, remaining bytes and the 4 KB page
    logic [12:0]            w_page;
    logic [12:0]            w_lim;
    logic [BYTES_WIDTH-1:0] w_full;
    logic [12:0]            w_beats;
    logic [BYTES_WIDTH-1:0] w_cons;
    logic                   w_free;
    logic                   w_end_desc;

    assign w_off      = r_addr[LB-1:0];
    assign w_head     = (w_off != '0) || (r_rem < BYTES_WIDTH'(BPB));
    assign w_room     = (LB+1)'(BPB) - {1'b0, w_off};
    assign w_n        = (r_rem < BYTES_WIDTH'(w_room)) ? r_rem[LB:0] : w_room;
    assign w_end      = {1'b0, w_off} + w_n;
    assign w_strb     = w_head ? (({BPB{1'b1}} << w_off) &
                        (w_end[LB] ? {BPB{1'b1}} : ~({BPB{1'b1}} << w_end[LB-1:0]))) : {BPB{1'b1}};
    assign w_page     = (13'h1000 - {1'b0, r_addr[11:0]}) >> LB;
    assign w_lim      = (w_page < 13'(MAX_BEATS)) ? w_page : 13'(MAX_BEATS);
    assign w_full     = r_rem >> LB;
    assign w_beats    = (w_full < BYTES_WIDTH'(w_lim)) ? w_full[12:0] : w_lim;
    assign w_cons     = w_head ? BYTES_WIDTH'(w_n) : BYTES_WIDTH'(w_beats) << LB;
    assign w_free     = !r_valid || req_ready_i;
    assign w_end_desc = w_free && (r_rem == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_valid    <= 1'b0;
            r_req_addr <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_strb     <= '0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_size    <= 3'(LB);
            case (r_state)
                IDLE: if (start_i) begin
                    r_state <= RUN;
                    r_addr  <= (STREAM_TYPE != 0) ? desc_dst_addr_i : desc_src_addr_i;
                    r_rem   <= desc_bytes_i;
                end
                RUN: if (abort_i && r_valid && !req_ready_i) begin
                    r_state <= DRAIN;
                end else if (abort_i || w_end_desc) begin
                    r_state   <= IDLE;
                    r_valid   <= 1'b0;
                    r_done    <= 1'b0 | 1'b1;
                    r_aborted <= abort_i && !w_end_desc;
                end else if (w_free) begin
                    r_valid    <= 1'b1;
                    r_req_addr <= {r_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
                    r_len      <= w_head ? 8'd0 : 8'(w_beats - 13'd1);
                    r_strb     <= w_strb;
                    r_last     <= (r_rem == w_cons);
                    r_addr     <= r_addr + ADDR_WIDTH'(w_cons);
                    r_rem      <= r_rem - w_cons;
                end
                DRAIN: if (req_ready_i) begin
                    r_state   <= IDLE;
                    r_valid   <= 1'b0;
                    r_done    <= 1'b1;
                    r_aborted <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_valid_o = r_valid;
    assign req_addr_o  = r_req_addr;
    assign req_len_o   = r_len;
    assign req_size_o  = r_size;
    assign req_strb_o  = r_strb;
    assign req_last_o  = r_last;
    assign busy_o      = (r_state != IDLE);
    assign done_o      = r_done;
    assign aborted_o   = r_aborted;
endmodule
